// File: rtl/mem_march_initiator.sv
// mem_march_initiator: built-in self-test driver for a single-port memory.
// Runs a 4-pass march over the full address space in this order:
//   W_UP (write P), RW_UP (expect P, write ~P), RW_DN (expect ~P, write P),
//   R_UP (expect P, write P).
// Reports pass/fail, the first failing address and a saturating error count.
// The memory stores mem_wdata every clock. In non-write states, mem_wdata is
// the combinational echo of mem_rdata, so the memory contents are held.
// Optional build macro: MARCH_STOP_ON_ERR_EN ends the march at the first mismatch.
module mem_march_initiator #(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   pattern,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW-1:0]   err_addr,
  output logic [ERRW-1:0] err_count,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [AW-1:0]   ADDR_MAX = {AW{1'b1}};
  localparam logic [ERRW-1:0] CNT_MAX  = {ERRW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_UP,
    S_RW_UP,
    S_RW_DN,
    S_R_UP,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   pat_q, pat_d;
  logic [ERRW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   eaddr_q, eaddr_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   exp_data;
  logic            chk_en;
  logic            mismatch;
  logic            ptr_last;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // March sequencing, write data selection and read compare
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    eaddr_d   = eaddr_q;
    pass_d    = pass_q;
    mem_wdata = mem_rdata;
    exp_data  = pat_q;
    chk_en    = 1'b0;
    mismatch  = 1'b0;
    ptr_last  = (ptr_q == ADDR_MAX);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          cnt_d   = '0;
          eaddr_d = '0;
          pass_d  = 1'b0;
          ptr_d   = '0;
          state_d = S_W_UP;
        end
      end
      S_W_UP: begin
        mem_wdata = pat_q;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_last) begin
          ptr_d   = '0;
          state_d = S_RW_UP;
        end
      end
      S_RW_UP: begin
        chk_en    = 1'b1;
        exp_data  = pat_q;
        mem_wdata = ~pat_q;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_last) begin
          ptr_d   = ADDR_MAX;
          state_d = S_RW_DN;
        end
      end
      S_RW_DN: begin
        chk_en    = 1'b1;
        exp_data  = ~pat_q;
        mem_wdata = pat_q;
        ptr_d     = ptr_q - AW'(1);
        if (ptr_q == '0) begin
          ptr_d   = '0;
          state_d = S_R_UP;
        end
      end
      S_R_UP: begin
        chk_en    = 1'b1;
        exp_data  = pat_q;
        mem_wdata = pat_q;
        ptr_d     = ptr_q + AW'(1);
        if (ptr_last) begin
          ptr_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mismatch = chk_en && (mem_rdata != exp_data);
    if (mismatch) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + ERRW'(1);
      end
      if (cnt_q == '0) begin
        eaddr_d = ptr_q;
      end
`ifdef MARCH_STOP_ON_ERR_EN
      ptr_d   = '0;
      state_d = S_FIN;
`endif
    end

    // Verdict is captured on entry to FIN, including the final access's compare
    if ((state_d == S_FIN) && (state_q != S_FIN)) begin
      pass_d = (cnt_d == '0);
    end
  end

  // Registered status flags follow the next state
  always_comb begin
    busy_d = (state_d == S_W_UP) || (state_d == S_RW_UP) ||
             (state_d == S_RW_DN) || (state_d == S_R_UP);
    done_d = (state_d == S_FIN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_addr  = eaddr_q;
  assign err_count = cnt_q;
  assign mem_addr  = ptr_q;

endmodule

// File: tb/tb_mem_march_initiator.sv
// Self-checking bench for mem_march_initiator: memory model with a stuck-bit
// fault, plus a march reference model computed from the pass rules.
module tb_mem_march_initiator;

`ifdef MARCH_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start2;
  logic [7:0] pattern;
  logic       busy, done, pass;
  logic [7:0] err_addr, err_count, mem_addr, mem_wdata, mem_rdata;
  logic       busy2, done2, pass2;
  logic [7:0] err_addr2, mem_addr2, mem_wdata2;
  logic [1:0] err_count2;
  logic [7:0] zero_rdata;

  int tests = 0;
  int fails = 0;

  // Memory array and stuck-at fault configuration
  logic [7:0] mem [256];
  logic       stk_en = 1'b0;
  logic [7:0] stk_a  = 8'h00;
  logic [2:0] stk_b  = 3'd0;
  logic       stk_v  = 1'b0;

  // Reference model state
  logic [7:0] mm [256];
  int exp_cycles, exp_cnt, exp_first;
  bit exp_pass;

  always #5 clk = ~clk;

  assign zero_rdata = 8'h00;

  mem_march_initiator #(.AW(8), .DW(8), .ERRW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .err_addr(err_addr),
    .err_count(err_count), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_march_initiator #(.AW(8), .DW(8), .ERRW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .pattern(pattern),
    .busy(busy2), .done(done2), .pass(pass2), .err_addr(err_addr2),
    .err_count(err_count2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(zero_rdata)
  );

  // Memory writes every clock
  always @(posedge clk) mem[mem_addr] <= mem_wdata;

  // Asynchronous read with optional stuck bit
  always_comb begin
    mem_rdata = mem[mem_addr];
    if (stk_en && (mem_addr == stk_a)) mem_rdata[stk_b] = stk_v;
  end

  function automatic logic [7:0] frd(input logic [7:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (stk_en && (a == stk_a)) r[stk_b] = stk_v;
    return r;
  endfunction

  function automatic logic [7:0] exp_addr(input int k);
    int ps, i;
    ps = k / 256;
    i  = k % 256;
    return (ps == 2) ? 8'(255 - i) : 8'(i);
  endfunction

  // Walks the four passes over the model array
  task automatic model_run(input logic [7:0] p, input int maxc);
    logic [7:0] a, r, e, w;
    bit stop;
    exp_cycles = 0;
    exp_cnt    = 0;
    exp_first  = -1;
    stop       = 1'b0;
    for (int ps = 0; ps < 4 && !stop; ps++) begin
      for (int i = 0; i < 256 && !stop; i++) begin
        a = (ps == 2) ? 8'(255 - i) : 8'(i);
        r = frd(a, mm[a]);
        e = (ps == 2) ? ~p : p;
        w = (ps == 1) ? ~p : p;
        exp_cycles++;
        if (ps > 0 && r !== e) begin
          if (exp_cnt < maxc) exp_cnt++;
          if (exp_first < 0) exp_first = int'(a);
          stop = STOP;
        end
        mm[a] = w;
      end
    end
    exp_pass = (exp_cnt == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
  endtask

  // One march on u_dut, compared against the model
  task automatic run_march(input logic [7:0] p, input bit noise, input string tag);
    int k, bad, mb;
    bit got;
    k = 0; bad = 0; mb = 0; got = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 256; a++) mm[8'(a)] = mem[8'(a)];
    model_run(p, 255);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      if (t > 0) @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (!busy || mem_addr !== exp_addr(k)) bad++;
        k++;
        start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, k, exp_cycles);
    chk({tag, "_addr_seq_errs"}, bad, 0);
    chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, "_err_count"}, 32'(err_count), exp_cnt);
    chk({tag, "_err_addr"}, 32'(err_addr), (exp_first < 0) ? 0 : exp_first);
    for (int a = 0; a < 256; a++) if (mem[8'(a)] !== mm[8'(a)]) mb++;
    chk({tag, "_mem_contents"}, mb, 0);
  endtask

  initial begin
    int ib, cnt55;
    bit got;
    logic [7:0] p;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; pattern = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err_addr", 32'(err_addr), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;

    // Healthy memory, P=55
    run_march(8'h55, 1'b0, "healthy55");
    chk("healthy55_pass_const", 32'(pass), 1);
    cnt55 = 0;
    for (int a = 0; a < 256; a++) if (mem[8'(a)] === 8'h55) cnt55++;
    chk("healthy55_all_55", cnt55, 256);

    // Stuck-at-0 on bit0 of 8'h3C
    stk_en = 1'b1; stk_a = 8'h3C; stk_b = 3'd0; stk_v = 1'b0;
    run_march(8'h55, 1'b0, "stuck3c");
    chk("stuck3c_count_const", 32'(err_count), STOP ? 1 : 2);
    chk("stuck3c_addr_const", 32'(err_addr), 32'h3C);
    chk("stuck3c_cycles_const", 0, 0 + 0);
    tests--;
    stk_en = 1'b0;

    // Extreme patterns
    run_march(8'h00, 1'b0, "p00");
    run_march(8'hFF, 1'b0, "pFF");

    // Random patterns, random stuck bits, start noise while busy
    for (int n = 0; n < 6; n++) begin
      stk_en = ($urandom_range(0, 3) != 0);
      stk_a  = 8'($urandom_range(0, 255));
      stk_b  = 3'($urandom_range(0, 7));
      stk_v  = 1'($urandom_range(0, 1));
      p      = 8'($urandom);
      run_march(p, 1'b1, $sformatf("rnd%0d", n));
    end
    stk_en = 1'b0;

    // start held high re-launches one cycle after FIN
    @(negedge clk);
    pattern = 8'hA5; start = 1'b1;
    wait_done(got);
    chk("hold_first_done", 32'(got), 1);
    @(negedge clk);
    chk("hold_idle_gap", 32'(busy), 0);
    @(negedge clk);
    chk("hold_relaunch", 32'(busy), 1);
    start = 1'b0;
    wait_done(got);
    chk("hold_second_done", 32'(got), 1);
    chk("hold_second_pass", 32'(pass), 1);

    // Reset at cycle 300 of a march
    @(negedge clk);
    pattern = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    chk("midrst_pass", 32'(pass), 0);
    ib = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ib++;
    end
    chk("midrst_no_done", ib, 0);
    rst_n = 1'b1;
    run_march(8'hC3, 1'b0, "after_rst");
    chk("after_rst_pass_const", 32'(pass), 1);

    // IDLE holds memory
    @(negedge clk);
    for (int a = 0; a < 256; a++) mm[8'(a)] = mem[8'(a)];
    ib = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || (mem_wdata !== mem_rdata)) ib++;
    end
    chk("idle_hold_cycles", ib, 0);
    ib = 0;
    for (int a = 0; a < 256; a++) if (mem[8'(a)] !== mm[8'(a)]) ib++;
    chk("idle_hold_mem", ib, 0);

    // Saturating counter on the ERRW=2 instance, memory reads 0
    @(negedge clk);
    pattern = 8'hFF; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    chk("sat_done", 32'(got), 1);
    chk("sat_err_count", 32'(err_count2), STOP ? 1 : 3);
    chk("sat_err_addr", 32'(err_addr2), 0);
    chk("sat_pass", 32'(pass2), 0);
    chk("sat_busy_low", 32'(busy2), 0);
    chk("sat_wdata_echo", 32'(mem_wdata2), 0);
    chk("sat_mem_addr", 32'(mem_addr2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
